// File: rtl/instruction_fetch_unit.sv
// Two-byte instruction fetch: reads the low-address byte then the next byte from a
// byte-wide memory, assembles IR and requests one PC increment per byte consumed.
module instruction_fetch_unit #(
    parameter int unsigned TIMEOUT       = 15,
    parameter bit          LITTLE_ENDIAN = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic [15:0] pc_i,
    input  logic [7:0]  mem_data_i,
    input  logic        mem_valid_i,
    output logic [15:0] mem_addr_o,
    output logic        mem_read_o,
    output logic        pc_inc_o,
    output logic [15:0] ir_o,
    output logic        ir_valid_o,
    output logic        busy_o,
    output logic        fetch_err_o
);

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_e;

    localparam logic [7:0] TO = 8'(TIMEOUT);

    state_e      state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  lo_q, lo_d;
    logic [15:0] ir_q, ir_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        inc_q, inc_d;
    logic        err_q, err_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            lo_q    <= '0;
            ir_q    <= '0;
            cnt_q   <= '0;
            inc_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            lo_q    <= lo_d;
            ir_q    <= ir_d;
            cnt_q   <= cnt_d;
            inc_q   <= inc_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        lo_d    = lo_q;
        ir_d    = ir_q;
        cnt_d   = cnt_q;
        inc_d   = 1'b0;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    addr_d  = pc_i;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = LO;
                end
            end
            LO, HI: begin
                // Abort wins over both a arriving byte and an expiring wait count.
                if (abort_i) begin
                    state_d = IDLE;
                end else if (mem_valid_i) begin
                    cnt_d = '0;
                    inc_d = 1'b1;
                    if (state_q == LO) begin
                        lo_d    = mem_data_i;
                        addr_d  = addr_q + 16'd1;
                        state_d = HI;
                    end else begin
                        ir_d    = LITTLE_ENDIAN ? {mem_data_i, lo_q} : {lo_q, mem_data_i};
                        state_d = DONE;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_d == TO) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // addr_q already holds A+1 while in HI, so MemAddr is a plain register.
    assign mem_addr_o  = addr_q;
    assign mem_read_o  = (state_q == LO) || (state_q == HI);
    assign busy_o      = mem_read_o;
    assign pc_inc_o    = inc_q;
    assign ir_o        = ir_q;
    assign ir_valid_o  = (state_q == DONE);
    assign fetch_err_o = err_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench: a little-endian and a big-endian instance (TIMEOUT=3) share stimulus
// and a byte memory model; each scenario task checks its own hand-computed values.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] pc = '0;
    logic        valid = 1'b0;
    logic [7:0]  mem_data;
    logic [7:0]  mem [0:65535];

    logic [15:0] addr_a, addr_b, ir_a, ir_b;
    logic        read_a, read_b, inc_a, inc_b, irv_a, irv_b, busy_a, busy_b, err_a, err_b;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    always_comb mem_data = mem[addr_a];

    instruction_fetch_unit #(.TIMEOUT(3), .LITTLE_ENDIAN(1'b1)) dut_a (
        .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort), .pc_i(pc),
        .mem_data_i(mem_data), .mem_valid_i(valid), .mem_addr_o(addr_a),
        .mem_read_o(read_a), .pc_inc_o(inc_a), .ir_o(ir_a), .ir_valid_o(irv_a),
        .busy_o(busy_a), .fetch_err_o(err_a));

    instruction_fetch_unit #(.TIMEOUT(3), .LITTLE_ENDIAN(1'b0)) dut_b (
        .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort), .pc_i(pc),
        .mem_data_i(mem_data), .mem_valid_i(valid), .mem_addr_o(addr_b),
        .mem_read_o(read_b), .pc_inc_o(inc_b), .ir_o(ir_b), .ir_valid_o(irv_b),
        .busy_o(busy_b), .fetch_err_o(err_b));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        nvec++; if (ir_a !== 16'h0000) begin nerr++; $display("FAIL rst_ir: got %h want 0000", ir_a); end
        nvec++; if (addr_a !== 16'h0000) begin nerr++; $display("FAIL rst_addr: got %h want 0000", addr_a); end
        nvec++; if ({read_a, inc_a, irv_a, busy_a, err_a} !== 5'b0) begin nerr++; $display("FAIL rst_ctl: got %b want 00000", {read_a, inc_a, irv_a, busy_a, err_a}); end
        nvec++; if ({read_b, inc_b, irv_b, busy_b, err_b, ir_b} !== 21'b0) begin nerr++; $display("FAIL rst_b: got %h want 0", {read_b, inc_b, irv_b, busy_b, err_b, ir_b}); end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_zero_wait();
        mem[16'h0040] = 8'h34; mem[16'h0041] = 8'h12;
        pc = 16'h0040; start = 1'b1; valid = 1'b1;
        tick(); start = 1'b0; pc = 16'h5555;  // PC changes must not move MemAddr
        nvec++; if (addr_a !== 16'h0040) begin nerr++; $display("FAIL zw_addr_lo: got %h want 0040", addr_a); end
        nvec++; if ({read_a, busy_a, inc_a, irv_a} !== 4'b1100) begin nerr++; $display("FAIL zw_ctl_lo: got %b want 1100", {read_a, busy_a, inc_a, irv_a}); end
        tick();
        nvec++; if (addr_a !== 16'h0041) begin nerr++; $display("FAIL zw_addr_hi: got %h want 0041", addr_a); end
        nvec++; if ({read_a, busy_a, inc_a, irv_a} !== 4'b1110) begin nerr++; $display("FAIL zw_ctl_hi: got %b want 1110", {read_a, busy_a, inc_a, irv_a}); end
        tick();
        nvec++; if (ir_a !== 16'h1234) begin nerr++; $display("FAIL zw_ir_le: got %h want 1234", ir_a); end
        nvec++; if (ir_b !== 16'h3412) begin nerr++; $display("FAIL zw_ir_be: got %h want 3412", ir_b); end
        nvec++; if ({read_a, busy_a, inc_a, irv_a} !== 4'b0011) begin nerr++; $display("FAIL zw_ctl_done: got %b want 0011", {read_a, busy_a, inc_a, irv_a}); end
        tick();
        nvec++; if ({read_a, busy_a, inc_a, irv_a} !== 4'b0000) begin nerr++; $display("FAIL zw_ctl_idle: got %b want 0000", {read_a, busy_a, inc_a, irv_a}); end
        valid = 1'b0;
    endtask

    task automatic test_wrap_waits();
        mem[16'hFFFF] = 8'hAB; mem[16'h0000] = 8'hCD;
        pc = 16'hFFFF; start = 1'b1; valid = 1'b0;
        tick(); start = 1'b0;
        nvec++; if (addr_b !== 16'hFFFF) begin nerr++; $display("FAIL ww_addr_lo: got %h want ffff", addr_b); end
        tick(); tick(); valid = 1'b1;
        nvec++; if ({busy_b, inc_b, err_b} !== 3'b100) begin nerr++; $display("FAIL ww_wait_lo: got %b want 100", {busy_b, inc_b, err_b}); end
        tick(); valid = 1'b0;
        nvec++; if (addr_b !== 16'h0000) begin nerr++; $display("FAIL ww_addr_wrap: got %h want 0000", addr_b); end
        nvec++; if (inc_b !== 1'b1) begin nerr++; $display("FAIL ww_inc_lo: got %b want 1", inc_b); end
        tick();
        nvec++; if ({busy_b, inc_b, irv_b} !== 3'b100) begin nerr++; $display("FAIL ww_wait_hi: got %b want 100", {busy_b, inc_b, irv_b}); end
        tick(); valid = 1'b1;
        nvec++; if (irv_b !== 1'b0) begin nerr++; $display("FAIL ww_early_irv: got %b want 0", irv_b); end
        tick(); valid = 1'b0;
        nvec++; if (irv_b !== 1'b1) begin nerr++; $display("FAIL ww_irv_at6: got %b want 1", irv_b); end
        nvec++; if (ir_b !== 16'hABCD) begin nerr++; $display("FAIL ww_ir_be: got %h want abcd", ir_b); end
        nvec++; if (ir_a !== 16'hCDAB) begin nerr++; $display("FAIL ww_ir_le: got %h want cdab", ir_a); end
        tick();
    endtask

    task automatic test_timeout();
        pc = 16'h0300; start = 1'b1; valid = 1'b0;
        tick(); start = 1'b0;
        nvec++; if ({busy_a, err_a} !== 2'b10) begin nerr++; $display("FAIL to_enter: got %b want 10", {busy_a, err_a}); end
        tick(); tick();
        nvec++; if ({busy_a, err_a, inc_a} !== 3'b100) begin nerr++; $display("FAIL to_wait2: got %b want 100", {busy_a, err_a, inc_a}); end
        tick();
        nvec++; if ({busy_a, err_a, inc_a, irv_a} !== 4'b0100) begin nerr++; $display("FAIL to_expire: got %b want 0100", {busy_a, err_a, inc_a, irv_a}); end
        nvec++; if (ir_a !== 16'hCDAB || ir_b !== 16'hABCD) begin nerr++; $display("FAIL to_ir_kept: got %h/%h want cdab/abcd", ir_a, ir_b); end
        tick();
        nvec++; if (err_a !== 1'b1) begin nerr++; $display("FAIL to_err_sticky: got %b want 1", err_a); end
        start = 1'b1;
        tick(); start = 1'b0; abort = 1'b1;
        nvec++; if ({busy_a, err_a} !== 2'b10) begin nerr++; $display("FAIL to_restart_clr: got %b want 10", {busy_a, err_a}); end
        tick(); abort = 1'b0;
        nvec++; if ({busy_a, err_a} !== 2'b00) begin nerr++; $display("FAIL to_abort_lo: got %b want 00", {busy_a, err_a}); end
    endtask

    task automatic test_abort_collision();
        pc = 16'h0040; start = 1'b1; valid = 1'b1;
        tick(); start = 1'b0;
        tick(); abort = 1'b1;
        nvec++; if ({busy_a, inc_a} !== 2'b11) begin nerr++; $display("FAIL ab_hi_inc: got %b want 11", {busy_a, inc_a}); end
        tick(); abort = 1'b0; valid = 1'b0;
        nvec++; if ({busy_a, inc_a, irv_a, err_a} !== 4'b0000) begin nerr++; $display("FAIL ab_idle: got %b want 0000", {busy_a, inc_a, irv_a, err_a}); end
        nvec++; if (ir_a !== 16'hCDAB || ir_b !== 16'hABCD) begin nerr++; $display("FAIL ab_ir_kept: got %h/%h want cdab/abcd", ir_a, ir_b); end
        tick();
        nvec++; if ({busy_a, irv_a} !== 2'b00) begin nerr++; $display("FAIL ab_still_idle: got %b want 00", {busy_a, irv_a}); end
    endtask

    task automatic test_back_to_back();
        mem[16'h0100] = 8'h11; mem[16'h0101] = 8'h22;
        mem[16'h0200] = 8'h33; mem[16'h0201] = 8'h44;
        pc = 16'h0100; start = 1'b1; valid = 1'b1;
        tick(); pc = 16'h0200;
        nvec++; if (addr_a !== 16'h0100) begin nerr++; $display("FAIL bb_addr1: got %h want 0100", addr_a); end
        tick(); tick();
        nvec++; if ({irv_a, ir_a} !== {1'b1, 16'h2211}) begin nerr++; $display("FAIL bb_ir1: got %b/%h want 1/2211", irv_a, ir_a); end
        tick();
        nvec++; if ({busy_a, inc_a, irv_a} !== 3'b000) begin nerr++; $display("FAIL bb_start_in_done: got %b want 000", {busy_a, inc_a, irv_a}); end
        tick(); start = 1'b0;
        nvec++; if ({busy_a, addr_a} !== {1'b1, 16'h0200}) begin nerr++; $display("FAIL bb_addr2: got %b/%h want 1/0200", busy_a, addr_a); end
        tick(); tick(); valid = 1'b0;
        nvec++; if ({irv_a, ir_a, ir_b} !== {1'b1, 16'h4433, 16'h3344}) begin nerr++; $display("FAIL bb_ir2: got %b/%h/%h want 1/4433/3344", irv_a, ir_a, ir_b); end
        tick();
    endtask

    task automatic test_reset_mid_fetch();
        pc = 16'h0040; start = 1'b1; valid = 1'b1;
        tick(); start = 1'b0;
        tick(); valid = 1'b0;
        nvec++; if ({read_a, busy_a, inc_a} !== 3'b111) begin nerr++; $display("FAIL rm_hi: got %b want 111", {read_a, busy_a, inc_a}); end
        #2 rst = 1'b1;
        #1;
        nvec++; if ({read_a, busy_a, inc_a, irv_a} !== 4'b0000) begin nerr++; $display("FAIL rm_async_ctl: got %b want 0000", {read_a, busy_a, inc_a, irv_a}); end
        nvec++; if ({ir_a, addr_a} !== 32'h0) begin nerr++; $display("FAIL rm_async_regs: got %h/%h want 0000/0000", ir_a, addr_a); end
        #2 rst = 1'b0;
        tick();
        nvec++; if ({busy_a, irv_a, ir_a} !== 18'h0) begin nerr++; $display("FAIL rm_idle: got %b/%b/%h want 0/0/0000", busy_a, irv_a, ir_a); end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wrap_waits();
        test_timeout();
        test_abort_collision();
        test_back_to_back();
        test_reset_mid_fetch();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Fetches one 16-bit instruction word from the byte-wide memory, starting at the program counter address supplied by the address register file. It assembles the word into the instruction register and pulses a PC-increment request for each byte consumed, keeping the address register file's PC in step. It sits between the address register file (PC on OutC) and the memory/decode stage.

## Interface
- TIMEOUT, 15: consecutive wait cycles without MemValid before a fetch is abandoned; legal range 1..255.
- LITTLE_ENDIAN, 1: 1 means the first byte fetched is IR[7:0]; 0 means the first byte fetched is IR[15:8].

- Clock  input  1  system clock; all state changes on the rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Start  input  1  fetch request; sampled only in IDLE.
- Abort  input  1  synchronous cancel of an in-flight fetch.
- PC  input  16  current PC from the address register file; latched on Start.
- MemData  input  8  read data from memory.
- MemValid  input  1  MemData valid this cycle; honoured only while MemRead=1.
- MemAddr  output  16  byte address driven to memory.
- MemRead  output  1  read request.
- PcInc  output  1  one-cycle pulse requesting PC+1 in the address register file.
- IR  output  16  instruction register.
- IRValid  output  1  one-cycle pulse when IR has just been loaded.
- Busy  output  1  high in LO and HI states.
- FetchErr  output  1  sticky timeout flag.

## Operation
- States: IDLE, LO, HI, DONE. All outputs are decoded from registered state only, with no combinational path from inputs to outputs.
- Reset state: IDLE. Reset drives IR=0, MemAddr=0, MemRead=0, PcInc=0, IRValid=0, Busy=0, FetchErr=0, and the wait counter to 0.
- IDLE:
  - Start=1 latches A=PC, clears FetchErr and the wait counter, and moves to LO.
  - Start=0 keeps the block in IDLE.
- LO:
  - Drives MemRead=1 and MemAddr=A.
  - MemValid=1 stores the byte, clears the wait counter and moves to HI. PcInc is high for the next cycle.
- HI:
  - Drives MemRead=1 and MemAddr=A+1, modulo 2^16 (A=FFFF gives 0000).
  - MemValid=1 loads IR with both bytes, ordered per LITTLE_ENDIAN, and moves to DONE. PcInc is high for the next cycle.
- DONE: IRValid=1 for exactly one cycle, then IDLE. Start asserted during DONE is ignored.
- Wait counting: in LO or HI, each cycle with MemValid=0 increments the counter. When the counter reaches TIMEOUT, the block sets FetchErr=1 and moves to IDLE. IR is unchanged and IRValid is not pulsed.
- Abort in LO or HI returns the block to IDLE on that edge:
  - Abort has priority over MemValid and over timeout.
  - The byte arriving on that edge is discarded, and no PcInc is issued for it.
  - FetchErr is unchanged.
- Abort in IDLE or DONE has no effect.
- Start asserted outside IDLE is ignored; it is not queued.
- A low-byte PcInc already issued is not retracted by a later Abort or timeout. PC then stays advanced by 1; recovering from that is the controller's job.
- The PC input is used only at Start. Later changes to PC do not affect MemAddr.
- Reset asserted mid-fetch forces IDLE and the reset values immediately, without waiting for a clock edge.

## Timing
- Zero-wait memory: Start sampled at edge 0; LO during cycle 0–1; HI during cycle 1–2; DONE (IRValid=1) during cycle 2–3; IDLE from edge 3.
  - Minimum Start-to-IRValid latency is 2 cycles.
  - Back-to-back fetches: one fetch every 4 cycles, because Start must be presented in IDLE.
- PcInc: high in the cycle immediately following each accepted byte.
  - Zero-wait fetch: high during cycles 1–2 and 2–3, coincident with HI and DONE.
  - Each PcInc is a single cycle, including back-to-back.
- Each wait cycle in LO or HI adds exactly 1 cycle of latency.
- Timeout: with MemValid held low from entry into LO, IDLE and FetchErr=1 are reached TIMEOUT edges after entering LO.

## Test plan
- Zero-wait fetch, little-endian: PC=0x0040; mem[0x40]=0x34, mem[0x41]=0x12; Start for 1 cycle.
  - Required: MemAddr 0x0040 then 0x0041; IR=0x1234 with IRValid in the 3rd cycle after Start; exactly two PcInc pulses; Busy high for 2 cycles.
- Wrap with waits, LITTLE_ENDIAN=0: PC=0xFFFF; 2 wait cycles on each byte; mem[0xFFFF]=0xAB, mem[0x0000]=0xCD.
  - Required: second MemAddr=0x0000; IR=0xABCD; IRValid 6 cycles after Start.
- Timeout, TIMEOUT=3: Start with MemValid never asserted.
  - Required: IDLE after 3 cycles in LO; FetchErr=1; IR keeps its previous value; no PcInc; the next Start clears FetchErr.
- Abort collision: MemValid=1 and Abort=1 on the same edge in HI.
  - Required: IDLE next cycle; IR unchanged; only the low-byte PcInc was issued; no IRValid.
- Reset mid-fetch: assert Reset asynchronously during HI with MemRead=1.
  - Required: MemRead, Busy and PcInc drop without a clock edge; IR=0; state IDLE.
  - A Start held high during DONE of a prior fetch must not begin a new fetch until IDLE.
